mux_4to1: RTL and testbench
===========================

// Module: mux_4to1
// PURPOSE
//   Registered 4-to-1 selector: two select bits (s1 MSB, s0 LSB) pick one of four data inputs a/b/c/d.
//   The selected value is presented on f one clock after sampling.
//   Generic leaf block used wherever a clocked one-of-four data choice is needed.
// PARAMETERS
//   WIDTH  1  bit width of a, b, c, d and f
// PORTS
//   clk  in   1      single clock; all state updates on rising edge
//   rst  in   1      reset, synchronous, active-high
//   en   in   1      capture enable; 1 = load selected input into f, 0 = hold f
//   s0   in   1      select LSB
//   s1   in   1      select MSB
//   a    in   WIDTH  data input, selected when {s1,s0}=2'b00
//   b    in   WIDTH  data input, selected when {s1,s0}=2'b01
//   c    in   WIDTH  data input, selected when {s1,s0}=2'b10
//   d    in   WIDTH  data input, selected when {s1,s0}=2'b11
//   f    out  WIDTH  registered mux output
//   f_comb out WIDTH combinational mux output (present only with MUX_COMB_OUT_EN)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst is synchronous and active-high.
//   - Select decode: sel={s1,s0}; 00->a, 01->b, 10->c, 11->d; no other encodings exist.
//   - At each rising clk edge, in priority order:
//     rst=1          -> f <= 0 (all WIDTH bits), regardless of en/sel/data.
//     rst=0, en=1    -> f <= selected input, sampled at that edge.
//     rst=0, en=0    -> f holds its previous value.
//   - Latency: exactly 1 cycle from select/data sample to f; throughput one new value per cycle.
//   - Reset value: f=0. f is undefined only before the first rst edge; the bench must assert rst first.
//   - Reset mid-operation: f clears on the first edge with rst=1 and stays 0 while rst is held.
//   - Select and data changing in the same cycle: f takes the new select applied to the new data.
//   - X/Z on select: no special handling; no internal state besides f.
//   - Width rule: pure bitwise pass-through; no arithmetic, extension or truncation.
// CONFIGURATION
//   MUX_COMB_OUT_EN defined:
//     - adds output port f_comb [WIDTH-1:0].
//     - f_comb is the unregistered selected input, same cycle.
//     - f_comb is unaffected by rst and en.
//   MUX_COMB_OUT_EN undefined:
//     - port f_comb is absent.
//     - only the registered f exists; f behaves identically in both builds.
// STRUCTURE
//   - Package mux_pkg: typedef logic [1:0] sel_t.
//   - mux_pkg localparams: SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
//   - Sub-module mux4_comb (parameter WIDTH): purely combinational decode of sel to y.
//   - Top mux_4to1 instantiates mux4_comb and owns the output register plus rst/en logic.
//   - mux4_comb's y drives f_comb directly when MUX_COMB_OUT_EN is defined.
// TESTING (WIDTH=1 unless noted)
//   1. Reset: rst=1 for 2 edges with a=b=c=d=1, en=1 -> f=0 after first edge, remains 0.
//   2. Exhaustive: rst=0, en=1; sweep all 64 combos of {s1,s0,a,b,c,d}, one per cycle
//      -> f one cycle later equals a/b/c/d per select (e.g. s1=1,s0=0,c=1,others 0 -> f=1).
//   3. Hold: load f=1 via sel=11,d=1; then en=0, d=0, sel=00, a=0 for 3 cycles -> f stays 1.
//   4. Mid-op reset: f=1 steady with en=1, pulse rst=1 one cycle -> f=0 that edge, f=1 next edge after rst=0.
//   5. WIDTH=8: a=8'h11, b=8'h22, c=8'h44, d=8'h88, cycle sel 00..11 -> f=11,22,44,88 each one cycle late.
//   6. MUX_COMB_OUT_EN: sel=01, b=1, en=0, rst=1 -> f_comb=1 same cycle while f=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared select type and select encodings for the registered 4-to-1 selector.
package mux_pkg;

   // Two-bit select word, {s1, s0}
   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage : mux_pkg

// File: rtl/mux4_comb.sv
// Purely combinational one-of-four data decode: y follows the selected input.
module mux4_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  sel_t             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] y
);

   // Route the input picked by sel straight through, bit for bit
   always_comb begin
      // NOTE: y gets a value before the case so no path can leave it unassigned and infer a latch.
      y = a;
      case (sel)
         SEL_A:   y = a;
         SEL_B:   y = b;
         SEL_C:   y = c;
         SEL_D:   y = d;
         default: y = a;
      endcase
   end

endmodule : mux4_comb

// File: rtl/mux_4to1.sv
// Registered 4-to-1 selector: {s1,s0} picks a/b/c/d, presented on f one clock later.
// Optional build macro MUX_COMB_OUT_EN adds f_comb, the same-cycle unregistered selection.
module mux_4to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s0,
   input  logic             s1,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] f
`ifdef MUX_COMB_OUT_EN
   ,
   output logic [WIDTH-1:0] f_comb
`endif
);

   sel_t             sel;
   logic [WIDTH-1:0] y;

   assign sel = {s1, s0};

   mux4_comb #(
      .WIDTH (WIDTH)
   ) u_mux4_comb (
      .sel (sel),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (y)
   );

`ifdef MUX_COMB_OUT_EN
   // Combinational tap ignores rst and en by design
   assign f_comb = y;
`else
   // Without the tap, the decoded value only feeds the output register
`endif

   // Output register: synchronous clear has priority, then enabled capture, otherwise hold
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      if (rst) begin
         f <= '0;
      end else if (en) begin
         f <= y;
      end
   end

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: table-driven WIDTH=1 vectors, a WIDTH=8 sequence,
// and the same-cycle f_comb check when MUX_COMB_OUT_EN is defined.
module tb_mux_4to1;
   import mux_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=1 instance
   logic rst, en, s0, s1, a, b, c, d, f;
   // WIDTH=8 instance
   logic       rst8, en8, s0_8, s1_8;
   logic [7:0] a8, b8, c8, d8, f8;
`ifdef MUX_COMB_OUT_EN
   logic       f_comb;
   logic [7:0] f_comb8;
`endif

   mux_4to1 #(.WIDTH(1)) dut (
      .clk (clk), .rst (rst), .en (en), .s0 (s0), .s1 (s1),
      .a (a), .b (b), .c (c), .d (d),
      .f (f)
`ifdef MUX_COMB_OUT_EN
      , .f_comb (f_comb)
`endif
   );

   mux_4to1 #(.WIDTH(8)) dut8 (
      .clk (clk), .rst (rst8), .en (en8), .s0 (s0_8), .s1 (s1_8),
      .a (a8), .b (b8), .c (c8), .d (d8),
      .f (f8)
`ifdef MUX_COMB_OUT_EN
      , .f_comb (f_comb8)
`endif
   );

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] sel;
      logic       a;
      logic       b;
      logic       c;
      logic       d;
      logic       exp_f;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] val;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic pop_check(input logic [7:0] act);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL scoreboard_empty: got output %h with no pending expectation", act);
      end else begin
         e = sb.pop_front();
         check(e.name, act, e.val);
      end
   endtask

   function automatic logic pick1(input logic [1:0] sel, input logic va, input logic vb,
                                  input logic vc, input logic vd);
      case (sel)
         2'b00:   return va;
         2'b01:   return vb;
         2'b10:   return vc;
         default: return vd;
      endcase
   endfunction

   function automatic vec_t mk(input logic r, input logic e, input logic [1:0] sel,
                               input logic va, input logic vb, input logic vc, input logic vd,
                               input logic exp_f, input string name);
      vec_t v;
      v.rst = r; v.en = e; v.sel = sel;
      v.a = va; v.b = vb; v.c = vc; v.d = vd;
      v.exp_f = exp_f; v.name = name;
      return v;
   endfunction

   initial begin
      logic [5:0] combo;
      vec_t       v;
      exp_t       e;

      rst = 1'b1; en = 1'b0; {s1, s0} = 2'b00; {a, b, c, d} = 4'b0000;
      rst8 = 1'b1; en8 = 1'b0; {s1_8, s0_8} = 2'b00; a8 = '0; b8 = '0; c8 = '0; d8 = '0;

      // Reset held for two edges with every input high
      vecs.push_back(mk(1, 1, 2'b11, 1, 1, 1, 1, 1'b0, "reset_edge1"));
      vecs.push_back(mk(1, 1, 2'b01, 1, 1, 1, 1, 1'b0, "reset_edge2"));
      // Exhaustive sweep of {s1,s0,a,b,c,d}
      for (int i = 0; i < 64; i++) begin
         combo = 6'(i);
         vecs.push_back(mk(0, 1, combo[5:4], combo[3], combo[2], combo[1], combo[0],
                           pick1(combo[5:4], combo[3], combo[2], combo[1], combo[0]),
                           $sformatf("sweep_%0d", i)));
      end
      // Hold with en=0 while select and data move away
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 0, 1, 1'b1, "hold_load"));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1'b1, "hold_1"));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1'b1, "hold_2"));
      vecs.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 1'b1, "hold_3"));
      // Mid-operation reset pulse
      vecs.push_back(mk(0, 1, 2'b00, 1, 0, 0, 0, 1'b1, "midrst_pre"));
      vecs.push_back(mk(0, 1, 2'b00, 1, 0, 0, 0, 1'b1, "midrst_steady"));
      vecs.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0, 1'b0, "midrst_pulse"));
      vecs.push_back(mk(0, 1, 2'b00, 1, 0, 0, 0, 1'b1, "midrst_release"));
      // Reset with en=0 still clears
      vecs.push_back(mk(1, 0, 2'b00, 1, 1, 1, 1, 1'b0, "rst_over_en0"));
      vecs.push_back(mk(0, 0, 2'b11, 1, 1, 1, 1, 1'b0, "hold_zero_after_rst"));

      // Apply each vector, push its expectation, compare one edge later
      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         rst = v.rst; en = v.en; {s1, s0} = v.sel;
         a = v.a; b = v.b; c = v.c; d = v.d;
         e.val = {7'd0, v.exp_f}; e.name = v.name;
         sb.push_back(e);
         @(posedge clk); #1;
         pop_check({7'd0, f});
      end

      // WIDTH=8: reset, then cycle the select over distinct patterns
      rst8 = 1'b1; en8 = 1'b1;
      a8 = 8'h11; b8 = 8'h22; c8 = 8'h44; d8 = 8'h88;
      e.val = 8'h00; e.name = "w8_reset";
      sb.push_back(e);
      @(posedge clk); #1;
      pop_check(f8);
      rst8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         {s1_8, s0_8} = 2'(i);
         case (i)
            0:       e.val = 8'h11;
            1:       e.val = 8'h22;
            2:       e.val = 8'h44;
            default: e.val = 8'h88;
         endcase
         e.name = $sformatf("w8_sel%0d", i);
         sb.push_back(e);
         @(posedge clk); #1;
         pop_check(f8);
      end
      // Select and data change together: new select applied to new data
      {s1_8, s0_8} = 2'b10; c8 = 8'hA5; a8 = 8'h5A;
      e.val = 8'hA5; e.name = "w8_sel_data_same_cycle";
      sb.push_back(e);
      @(posedge clk); #1;
      pop_check(f8);

`ifdef MUX_COMB_OUT_EN
      // Combinational tap follows select while reset holds f at zero
      rst = 1'b1; en = 1'b0; {s1, s0} = 2'b01; {a, b, c, d} = 4'b0100;
      @(posedge clk); #1;
      check("comb_f_in_reset", {7'd0, f}, 8'h00);
      check("comb_f_comb_sel01", {7'd0, f_comb}, 8'h01);
      {s1, s0} = 2'b10; #1;
      check("comb_f_comb_sel10", {7'd0, f_comb}, 8'h00);
      {s1_8, s0_8} = 2'b11; d8 = 8'h3C; #1;
      check("comb_w8_same_cycle", f_comb8, 8'h3C);
`endif

      if (sb.size() != 0) begin
         total++;
         $display("FAIL scoreboard_leftover: %0d pending, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_mux_4to1
